ram_1r1w: RTL and testbench

RAM_1R1W -- requirements
Module: ram_1r1w

---
 rtl/ram_pkg.sv | 33 +++
 rtl/ram_1r1w_if.sv | 29 ++
 rtl/ram_clear_ctrl.sv | 54 +++++
 rtl/ram_1r1w.sv | 104 ++++++++++
 tb/tb_ram_1r1w.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the 1R1W RAM.
//   state_e          : clear-controller states
//   RDW_WRITE_FIRST  : same-address read during write returns the merged new word
//   RDW_READ_FIRST   : same-address read during write returns the old word
//   byte_merge()     : replace the enabled bytes of an old word with bytes of a new word
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR,
    READY
  } state_e;

  localparam int unsigned RDW_WRITE_FIRST = 0;
  localparam int unsigned RDW_READ_FIRST  = 1;

  // byte_merge works on the widest supported word; callers zero-extend and slice.
  localparam int unsigned MaxDataWidth = 256;
  localparam int unsigned MaxBeWidth   = MaxDataWidth / 8;

  function automatic logic [MaxDataWidth-1:0] byte_merge(
    input logic [MaxDataWidth-1:0] old_word,
    input logic [MaxDataWidth-1:0] new_word,
    input logic [MaxBeWidth-1:0]   be
  );
    logic [MaxDataWidth-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(MaxBeWidth); i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_1r1w_if.sv
// Request/response bundle of the 1R1W RAM.
//   master : requester side (drives wr_*, rd_en, rd_addr)
//   slave  : RAM side (drives rd_data, rd_valid, rd_err, wr_err, init_busy)
interface ram_1r1w_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_be;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    rd_err;
  logic                    wr_err;
  logic                    init_busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, rd_err, wr_err, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, rd_err, wr_err, init_busy
  );
endinterface

// File: rtl/ram_clear_ctrl.sv
// Clear sequencer: after reset walks every address once, requesting a write of the
// initial value, then parks in READY.
//   clk, rst    : clock, synchronous active-high reset
//   clr_we      : write INIT_VALUE to clr_addr this cycle
//   clr_addr    : word being cleared
//   init_busy   : clear in progress, user requests must be ignored
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_busy
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (32'(cnt_q) == DEPTH - 1) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign clr_we    = (state_q == CLEAR);
  assign clr_addr  = cnt_q;
  assign init_busy = (state_q == CLEAR);

endmodule

// File: rtl/ram_1r1w.sv
// One-read one-write synchronous RAM with byte enables, range checking and a
// post-reset clear sequence.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of ram_1r1w_if (write port, read port, status)
// DATA_WIDTH must be a multiple of 8 and at most ram_pkg::MaxDataWidth.
module ram_1r1w
  import ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 16,
  parameter int unsigned           ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned           RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic        clk,
  input logic        rst,
  ram_1r1w_if.slave  bus
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  init_busy;

  ram_clear_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  logic wr_oor, rd_oor, wr_req, wr_ok, rd_ok;
  assign wr_oor = 32'(bus.wr_addr) >= DEPTH;
  assign rd_oor = 32'(bus.rd_addr) >= DEPTH;
  assign wr_req = bus.wr_en && !init_busy;
  assign wr_ok  = wr_req && !wr_oor;
  assign rd_ok  = bus.rd_en && !init_busy;

  // Merged write word; also the forwarded value for write-first same-address reads.
  logic [MaxDataWidth-1:0] wr_merged_full;
  logic [DATA_WIDTH-1:0]   wr_merged;
  always_comb begin
    wr_merged_full = byte_merge(MaxDataWidth'(mem[bus.wr_addr]),
                                MaxDataWidth'(bus.wr_data),
                                MaxBeWidth'(bus.wr_be));
    wr_merged      = wr_merged_full[DATA_WIDTH-1:0];
  end

  // Storage has no reset; contents come only from the clear sequence and writes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VALUE;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= wr_merged;
    end
  end

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_err_q, rd_err_d;
  logic                  wr_err_q, wr_err_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_ok;
    rd_err_d   = rd_ok && rd_oor;
    wr_err_d   = wr_req && wr_oor;
    if (rd_ok) begin
      if (rd_oor) begin
        rd_data_d = '0;
      end else if (RDW_MODE == RDW_WRITE_FIRST && wr_ok && bus.wr_addr == bus.rd_addr) begin
        rd_data_d = wr_merged;
      end else begin
        rd_data_d = mem[bus.rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_ram_1r1w.sv
// Bench for ram_1r1w: three instances share one stimulus stream.
//   u_a : DEPTH 16, write-first   u_b : DEPTH 16, read-first   u_c : DEPTH 12, write-first
module tb_ram_1r1w;

  localparam logic [31:0] IA = 32'hA5A5_0F0F;  // init value of u_a and u_b
  localparam logic [31:0] IC = 32'h1234_5678;  // init value of u_c

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;

  int tests;
  int fails;

  ram_1r1w_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_a ();
  ram_1r1w_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_b ();
  ram_1r1w_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_c ();

  assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;   assign if_c.wr_en = wr_en;
  assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr; assign if_c.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data; assign if_c.wr_data = wr_data;
  assign if_a.wr_be = wr_be;   assign if_b.wr_be = wr_be;   assign if_c.wr_be = wr_be;
  assign if_a.rd_en = rd_en;   assign if_b.rd_en = rd_en;   assign if_c.rd_en = rd_en;
  assign if_a.rd_addr = rd_addr; assign if_b.rd_addr = rd_addr; assign if_c.rd_addr = rd_addr;

  ram_1r1w #(.DATA_WIDTH(32), .DEPTH(16), .RDW_MODE(0), .INIT_VALUE(IA)) u_a (
    .clk (clk), .rst (rst), .bus (if_a.slave)
  );
  ram_1r1w #(.DATA_WIDTH(32), .DEPTH(16), .RDW_MODE(1), .INIT_VALUE(IA)) u_b (
    .clk (clk), .rst (rst), .bus (if_b.slave)
  );
  ram_1r1w #(.DATA_WIDTH(32), .DEPTH(12), .RDW_MODE(0), .INIT_VALUE(IC)) u_c (
    .clk (clk), .rst (rst), .bus (if_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  // Counts busy observations after the reset edge, with rst already released.
  task automatic count_busy(output int n_a, output int n_c);
    n_a = 1;
    n_c = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (if_a.init_busy) n_a++;
      if (if_c.init_busy) n_c++;
    end
  endtask

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        exp_valid;
    logic [31:0] exp_a;
    logic [31:0] exp_c;
    logic        exp_c_rerr;
    logic        exp_c_werr;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int busy_a, busy_c, viol;
    tests = 0;
    fails = 0;

    vecs[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 1'b0, 4'd0,  1'b0, IA,           32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd3,  32'h11223344, 4'h5, 1'b0, 4'd0,  1'b0, IA,           32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd3,  1'b1, 32'hDE22BE44, 32'hDE22BE44, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd13, 32'hFFFFFFFF, 4'hF, 1'b1, 4'd2,  1'b1, IA,           IC,           1'b0, 1'b1};
    vecs[4]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd13, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd1,  1'b1, IA,           IC,           1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd5,  1'b1, IA,           IC,           1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'd7,  32'h01020304, 4'hC, 1'b1, 4'd15, 1'b1, IA,           32'h0,        1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'd2,  32'hCAFEF00D, 4'h0, 1'b1, 4'd7,  1'b1, 32'h01020F0F, 32'h01025678, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd2,  1'b1, IA,           IC,           1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'd8,  32'h0BADF00D, 4'hF, 1'b1, 4'd7,  1'b1, 32'h01020F0F, 32'h01025678, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd8,  1'b1, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 4'd0,  1'b0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0};

    // Reset state
    idle();
    rst = 1'b1;
    tick();
    chk("rst a rd_data",  if_a.rd_data, 32'h0);
    chk("rst a rd_valid", 32'(if_a.rd_valid), 32'h0);
    chk("rst a rd_err",   32'(if_a.rd_err), 32'h0);
    chk("rst a wr_err",   32'(if_a.wr_err), 32'h0);
    chk("rst a busy",     32'(if_a.init_busy), 32'h1);
    chk("rst c busy",     32'(if_c.init_busy), 32'h1);
    rst = 1'b0;

    // Clear duration, with requests ignored while busy
    busy_a = 1;
    busy_c = 1;
    viol   = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 10) begin
        wr_en = 1'b1; wr_addr = i[0] ? 4'd13 : 4'd0; wr_data = 32'h0BAD_0000 | 32'(i);
        wr_be = 4'hF; rd_en = 1'b1; rd_addr = 4'(i);
      end else begin
        idle();
      end
      tick();
      if (if_a.init_busy) busy_a++;
      if (if_c.init_busy) busy_c++;
      if (if_a.rd_valid || if_a.wr_err || if_b.rd_valid || if_b.wr_err ||
          if_c.rd_valid || if_c.wr_err || if_c.rd_err) viol++;
    end
    chk("busy cycles a", 32'(busy_a), 32'd16);
    chk("busy cycles c", 32'(busy_c), 32'd12);
    chk("responses while busy", 32'(viol), 32'd0);

    // Back-to-back sweep: every word holds its init value
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      rd_addr = 4'(i);
      tick();
      chk($sformatf("sweep a data %0d", i), if_a.rd_data, IA);
      chk($sformatf("sweep a valid %0d", i), 32'(if_a.rd_valid), 32'h1);
      chk($sformatf("sweep b data %0d", i), if_b.rd_data, IA);
      chk($sformatf("sweep c data %0d", i), if_c.rd_data, (i < 12) ? IC : 32'h0);
      chk($sformatf("sweep c valid %0d", i), 32'(if_c.rd_valid), 32'h1);
      chk($sformatf("sweep c err %0d", i), 32'(if_c.rd_err), (i < 12) ? 32'h0 : 32'h1);
    end
    idle();
    tick();
    chk("sweep end a valid", 32'(if_a.rd_valid), 32'h0);
    chk("sweep end a hold",  if_a.rd_data, IA);
    chk("sweep end c err",   32'(if_c.rd_err), 32'h0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      wr_be = vecs[i].wr_be; rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
      tick();
      chk($sformatf("vec%0d a valid", i), 32'(if_a.rd_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d a data", i), if_a.rd_data, vecs[i].exp_a);
      chk($sformatf("vec%0d a errs", i), {30'h0, if_a.rd_err, if_a.wr_err}, 32'h0);
      chk($sformatf("vec%0d b data", i), if_b.rd_data, vecs[i].exp_a);
      chk($sformatf("vec%0d c valid", i), 32'(if_c.rd_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d c data", i), if_c.rd_data, vecs[i].exp_c);
      chk($sformatf("vec%0d c rd_err", i), 32'(if_c.rd_err), 32'(vecs[i].exp_c_rerr));
      chk($sformatf("vec%0d c wr_err", i), 32'(if_c.wr_err), 32'(vecs[i].exp_c_werr));
    end

    // Read during write, same address
    idle();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hAAAAAAAA; wr_be = 4'hF;
    tick();
    wr_data = 32'h55555555; rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    chk("rdw a write-first", if_a.rd_data, 32'h55555555);
    chk("rdw b read-first",  if_b.rd_data, 32'hAAAAAAAA);
    chk("rdw c write-first", if_c.rd_data, 32'h55555555);
    wr_en = 1'b0;
    tick();
    chk("rdw a after", if_a.rd_data, 32'h55555555);
    chk("rdw b after", if_b.rd_data, 32'h55555555);
    idle();
    tick();

    // Reset in the middle of the clear sequence
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid-clear busy", 32'(if_a.init_busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(busy_a, busy_c);
    chk("restart busy a", 32'(busy_a), 32'd16);
    chk("restart busy c", 32'(busy_c), 32'd12);
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    chk("recleared a addr3", if_a.rd_data, IA);
    chk("recleared c addr3", if_c.rd_data, IC);
    rd_addr = 4'd5;
    tick();
    chk("recleared b addr5", if_b.rd_data, IA);
    idle();
    tick();
    chk("final a valid", 32'(if_a.rd_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
